fifo_ctrl: RTL and testbench

Control unit for the 32-bit register-array FIFO. Sequences writes and reads over 2**ADDR_W data entries built from 32-bit enabled registers, and produces the one-hot entry write enables, read select and output-register load. Also maintains head/tail pointers, occupancy count, full/empty status and per-request handshake/error status. Datapath (entries, read mux, output register) sits in the FIFO top level; this block holds no data.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/fifo_ctrl_if.sv | 45 ++++
 rtl/fifo_ctrl_ns.sv | 74 +++++++
 rtl/fifo_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO control unit.
package fifo_ctrl_pkg;

  localparam int unsigned AddrWDefault = 3;

  // Controller state, 3-bit encoding.
  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StNoOp    = 3'd1,
    StWrite   = 3'd2,
    StWrError = 3'd3,
    StRead    = 3'd4,
    StRdError = 3'd5,
    StRdWr    = 3'd6
  } state_e;

  // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
  function automatic int unsigned count_width(int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the FIFO top level and its controller.
// Optional almost_full/almost_empty signals exist when FIFO_CTRL_ALMOST_FLAGS_EN is defined.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) ();

  logic                   wr_en;
  logic                   rd_en;
  logic [2**ADDR_W-1:0]   we_entry;
  logic [ADDR_W-1:0]      rd_sel;
  logic                   rd_load;
  logic [ADDR_W:0]        data_count;
  logic                   full;
  logic                   empty;
  logic                   wr_ack;
  logic                   wr_err;
  logic                   rd_ack;
  logic                   rd_err;
  state_e                 state;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic                   almost_full;
  logic                   almost_empty;
`endif

  modport master (
    output wr_en, rd_en,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    input  almost_full, almost_empty,
`endif
    input  we_entry, rd_sel, rd_load, data_count, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err, state
  );

  modport slave (
    input  wr_en, rd_en,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    output almost_full, almost_empty,
`endif
    output we_entry, rd_sel, rd_load, data_count, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err, state
  );

endinterface

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state logic: request acceptance, pointers, count, status flags.
// Almost-flag next values exist when FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] head,
  input  logic [ADDR_W-1:0] tail,
  input  logic [ADDR_W:0]   count,
  output logic              wr_ok,
  output logic              rd_ok,
  output logic [ADDR_W-1:0] head_nxt,
  output logic [ADDR_W-1:0] tail_nxt,
  output logic [ADDR_W:0]   count_nxt,
  output state_e            state_nxt,
  output logic              wr_ack_nxt,
  output logic              wr_err_nxt,
  output logic              rd_ack_nxt,
  output logic              rd_err_nxt
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic              almost_full_nxt,
  output logic              almost_empty_nxt
`endif
);

  localparam int unsigned CntW = count_width(ADDR_W);
  localparam logic [ADDR_W:0] FullCnt = CntW'(2**ADDR_W);

  logic is_full;
  logic is_empty;

  // Acceptance, pointer/count update and next controller state.
  always_comb begin
    is_full  = (count == FullCnt);
    is_empty = (count == '0);
    rd_ok    = rd_en && !is_empty;
    // A read on the same cycle frees the slot a write into a full FIFO needs.
    wr_ok    = wr_en && (!is_full || rd_ok);

    head_nxt = rd_ok ? head + ADDR_W'(1) : head;
    tail_nxt = wr_ok ? tail + ADDR_W'(1) : tail;

    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CntW'(1);
      2'b01:   count_nxt = count - CntW'(1);
      default: count_nxt = count;
    endcase

    wr_ack_nxt = wr_ok;
    wr_err_nxt = wr_en && !wr_ok;
    rd_ack_nxt = rd_ok;
    rd_err_nxt = rd_en && !rd_ok;

    if (wr_err_nxt)          state_nxt = StWrError;
    else if (rd_err_nxt)     state_nxt = StRdError;
    else if (wr_ok && rd_ok) state_nxt = StRdWr;
    else if (wr_ok)          state_nxt = StWrite;
    else if (rd_ok)          state_nxt = StRead;
    else                     state_nxt = StNoOp;
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  // Almost flags track the count that will be registered this edge.
  always_comb begin
    almost_full_nxt  = (count_nxt == FullCnt - CntW'(1));
    almost_empty_nxt = (count_nxt == CntW'(1));
  end
`endif

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control unit: pointer/count/status registers and one-hot entry write decode.
// Define FIFO_CTRL_ALMOST_FLAGS_EN to add almost_full/almost_empty outputs.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic  clk,
  input  logic  reset_n,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned CntW = count_width(ADDR_W);
  localparam logic [ADDR_W:0] FullCnt = CntW'(2**ADDR_W);

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  state_e            state_q, state_d;
  logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic              rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic              wr_ok, rd_ok;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
`endif

  fifo_ctrl_ns #(
    .ADDR_W (ADDR_W)
  ) u_ns (
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .head       (head_q),
    .tail       (tail_q),
    .count      (count_q),
    .wr_ok      (wr_ok),
    .rd_ok      (rd_ok),
    .head_nxt   (head_d),
    .tail_nxt   (tail_d),
    .count_nxt  (count_d),
    .state_nxt  (state_d),
    .wr_ack_nxt (wr_ack_d),
    .wr_err_nxt (wr_err_d),
    .rd_ack_nxt (rd_ack_d),
    .rd_err_nxt (rd_err_d)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    .almost_full_nxt  (almost_full_d),
    .almost_empty_nxt (almost_empty_d)
`endif
  );

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      state_q  <= StInit;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      state_q  <= state_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  // Almost flags registered alongside the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b0;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`endif

  // One-hot entry write enable at the tail, only for an accepted write.
  always_comb begin
    bus.we_entry = '0;
    if (wr_ok) bus.we_entry[tail_q] = 1'b1;
  end

  assign bus.rd_load    = rd_ok;
  assign bus.rd_sel     = head_q;
  assign bus.data_count = count_q;
  assign bus.full       = (count_q == FullCnt);
  assign bus.empty      = (count_q == '0);
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (ADDR_W = 3, depth 8).
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  fifo_ctrl_if #(.ADDR_W(3)) bus ();

  fifo_ctrl #(
    .ADDR_W (3)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a request at the falling edge, check combinational outputs, then clock it in.
  task automatic drive(input string tag, input logic wr, input logic rd,
                       input logic [7:0] exp_we, input logic exp_ld);
    @(negedge clk);
    bus.wr_en = wr;
    bus.rd_en = rd;
    #1;
    chk({tag, ".we_entry"}, 32'(bus.we_entry), 32'(exp_we));
    chk({tag, ".rd_load"}, 32'(bus.rd_load), 32'(exp_ld));
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input state_e st, input int cnt, input logic wa,
                      input logic we, input logic ra, input logic re, input int hd);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".count"}, 32'(bus.data_count), 32'(cnt));
    chk({tag, ".full"}, 32'(bus.full), 32'(cnt == 8));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({tag, ".wr_ack"}, 32'(bus.wr_ack), 32'(wa));
    chk({tag, ".wr_err"}, 32'(bus.wr_err), 32'(we));
    chk({tag, ".rd_ack"}, 32'(bus.rd_ack), 32'(ra));
    chk({tag, ".rd_err"}, 32'(bus.rd_err), 32'(re));
    chk({tag, ".rd_sel"}, 32'(bus.rd_sel), 32'(hd));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(cnt == 7));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt == 1));
`endif
  endtask

  task automatic reset_vals(input string tag);
    regs(tag, StInit, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk({tag, ".we_entry"}, 32'(bus.we_entry), 32'h0);
    chk({tag, ".rd_load"}, 32'(bus.rd_load), 32'h0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #3;
    reset_vals("rst");

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    reset_vals("rst_rel");
    @(posedge clk);
    #1;
    regs("idle", StNoOp, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Fill: tail 0..7.
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("fill%0d", i), 1'b1, 1'b0, 8'(1 << i), 1'b0);
      regs($sformatf("fill%0d", i), StWrite, i + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
    drive("ovf", 1'b1, 1'b0, 8'h00, 1'b0);
    regs("ovf", StWrError, 8, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Drain: head 0..7, then underflow.
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00, 1'b1);
      regs($sformatf("drain%0d", i), StRead, 7 - i, 1'b0, 1'b0, 1'b1, 1'b0, (i + 1) % 8);
    end
    drive("udf", 1'b0, 1'b1, 8'h00, 1'b0);
    regs("udf", StRdError, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Wrap: write 5, read 5, write 6 (tail 5,6,7,0,1,2).
    for (int i = 0; i < 5; i++) drive($sformatf("wa%0d", i), 1'b1, 1'b0, 8'(1 << i), 1'b0);
    regs("wa", StWrite, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) drive($sformatf("wb%0d", i), 1'b0, 1'b1, 8'h00, 1'b1);
    regs("wb", StRead, 0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 6; i++) begin
      drive($sformatf("wc%0d", i), 1'b1, 1'b0, 8'(1 << ((5 + i) % 8)), 1'b0);
    end
    regs("wc", StWrite, 6, 1'b1, 1'b0, 1'b0, 1'b0, 5);

    // Async reset between edges clears control immediately.
    bus.wr_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    reset_vals("arst1");
    @(negedge clk);
    reset_n = 1'b1;

    // Empty with simultaneous wr & rd: write only, read rejected.
    drive("se", 1'b1, 1'b1, 8'h01, 1'b0);
    regs("se", StRdError, 1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i < 8; i++) drive($sformatf("sf%0d", i), 1'b1, 1'b0, 8'(1 << i), 1'b0);
    regs("sf", StWrite, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Full with simultaneous wr & rd: both accepted, count stays 8.
    drive("sfull", 1'b1, 1'b1, 8'h01, 1'b1);
    regs("sfull", StRdWr, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    drive("sidle", 1'b0, 1'b0, 8'h00, 1'b0);
    regs("sidle", StNoOp, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Mid-fill async reset at count 4.
    bus.wr_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    reset_vals("arst2");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive($sformatf("mf%0d", i), 1'b1, 1'b0, 8'(1 << i), 1'b0);
    regs("mf", StWrite, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    bus.wr_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    reset_vals("arst3");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    regs("post", StNoOp, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
